// File: rtl/multi_timer_core_if.sv
// Register-write bus from the peripheral bus-interface block into the timer core.
// The bus block drives one shared data word plus per-register write strobes.
interface multi_timer_core_if #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32
);
    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_BITS-1:0] sel;
    logic [WIDTH-1:0]   wrData;
    logic               countWe;
    logic               compareWe;
    logic               ctrlWe;
    logic               statusClr;

    modport master (
        output sel, wrData, countWe, compareWe, ctrlWe, statusClr
    );

    modport slave (
        input  sel, wrData, countWe, compareWe, ctrlWe, statusClr
    );
endinterface

// File: rtl/multi_timer_core.sv
// Purpose: NUM_CH independent compare-match counters/timers with sticky flags and one combined irq.
// Latency: register writes and counting act on the clock edge; irq follows its flag by one edge.
// Backpressure: none; every write strobe is accepted on the edge it is presented.
module multi_timer_core #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    multi_timer_core_if.slave       bus,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH*WIDTH-1:0] compare,
    output logic [NUM_CH*3-1:0]     ctrl,
    output logic [NUM_CH-1:0]       status,
    output logic                    irq
);
    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] irq_src;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cmp_q;
        logic [2:0]       ctl_q;   // {irqEn, oneShot, en}
        logic             st_q;
        logic             hit;
        logic             load;
        logic             match;

        // Out-of-range select values never equal any channel index, so they write nothing.
        assign hit   = (bus.sel == CH_BITS'(i));
        assign load  = bus.countWe && hit;
        assign match = ctl_q[0] && !load && (cnt_q == cmp_q);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                cmp_q <= '1;
                ctl_q <= '0;
                st_q  <= 1'b0;
            end else begin
                if (load) begin
                    cnt_q <= bus.wrData;
                end else if (match) begin
                    if (!ctl_q[1]) cnt_q <= '0;
                end else if (ctl_q[0]) begin
                    cnt_q <= cnt_q + WIDTH'(1);
                end

                if (match && ctl_q[1]) ctl_q[0] <= 1'b0;
                // A software ctrl write lands after the one-shot clear so the written value wins.
                if (bus.ctrlWe && hit) ctl_q <= bus.wrData[2:0];
                if (bus.compareWe && hit) cmp_q <= bus.wrData;

                if (bus.statusClr && bus.wrData[i]) st_q <= 1'b0;
                if (match) st_q <= 1'b1;
            end
        end

        assign count[i*WIDTH +: WIDTH]   = cnt_q;
        assign compare[i*WIDTH +: WIDTH] = cmp_q;
        assign ctrl[i*3 +: 3]            = ctl_q;
        assign status[i]                 = st_q;
        assign irq_src[i]                = st_q & ctl_q[2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= |irq_src;
    end
endmodule

// File: tb/tb_multi_timer_core.sv
// Directed bench for multi_timer_core built with three 32-bit channels.
module tb_multi_timer_core;
    localparam int NCH = 3;
    localparam int W   = 32;

    logic             clk;
    logic             reset;
    logic [NCH*W-1:0] count;
    logic [NCH*W-1:0] compare;
    logic [NCH*3-1:0] ctrl;
    logic [NCH-1:0]   status;
    logic             irq;

    int checks   = 0;
    int failures = 0;

    multi_timer_core_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

    multi_timer_core #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .count   (count),
        .compare (compare),
        .ctrl    (ctrl),
        .status  (status),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1ns after each edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic cw, input logic mw, input logic tw, input logic sc,
                      input logic [1:0] s, input logic [31:0] d);
        bus.sel       = s;
        bus.wrData    = d;
        bus.countWe   = cw;
        bus.compareWe = mw;
        bus.ctrlWe    = tw;
        bus.statusClr = sc;
        step(1);
        bus.countWe   = 1'b0;
        bus.compareWe = 1'b0;
        bus.ctrlWe    = 1'b0;
        bus.statusClr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_fr [1:5];
        exp_fr[1] = 1; exp_fr[2] = 2; exp_fr[3] = 3; exp_fr[4] = 0; exp_fr[5] = 1;

        reset         = 1'b0;
        bus.sel       = '0;
        bus.wrData    = '0;
        bus.countWe   = 1'b0;
        bus.compareWe = 1'b0;
        bus.ctrlWe    = 1'b0;
        bus.statusClr = 1'b0;
        step(2);

        chk("rst_count",   64'(count),   64'(0));
        chk("rst_compare", 64'(compare), 64'({NCH*W{1'b1}}));
        chk("rst_ctrl",    64'(ctrl),    64'(0));
        chk("rst_status",  64'(status),  64'(0));
        chk("rst_irq",     64'(irq),     64'(0));
        reset = 1'b1;

        // Free-run with interrupt, then write-one-to-clear.
        wr(0, 1, 0, 0, 2'd0, 32'd3);
        wr(0, 0, 1, 0, 2'd0, 32'h5);
        chk("fr_start", 64'(count[31:0]), 64'(0));
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk($sformatf("fr_cnt%0d", k), 64'(count[31:0]), 64'(exp_fr[k]));
            if (k == 3) chk("fr_st_pre", 64'(status[0]), 64'(0));
            if (k == 4) begin
                chk("fr_st_set",  64'(status[0]), 64'(1));
                chk("fr_irq_lag", 64'(irq),       64'(0));
            end
            if (k == 5) chk("fr_irq", 64'(irq), 64'(1));
        end
        wr(0, 0, 0, 1, 2'd0, 32'h1);
        chk("fr_clr_st",  64'(status[0]), 64'(0));
        chk("fr_clr_irq", 64'(irq),       64'(1));
        step(1);
        chk("fr_irq_off", 64'(irq), 64'(0));

        // One-shot on channel 1, irq disabled.
        do_reset();
        wr(0, 1, 0, 0, 2'd1, 32'd2);
        wr(0, 0, 1, 0, 2'd1, 32'h3);
        step(3);
        chk("os_cnt",  64'(count[63:32]), 64'(2));
        chk("os_ctrl", 64'(ctrl[5:3]),    64'(3'b010));
        chk("os_st",   64'(status[1]),    64'(1));
        step(1);
        chk("os_hold", 64'(count[63:32]), 64'(2));
        chk("os_irq",  64'(irq),          64'(0));
        wr(0, 0, 1, 0, 2'd1, 32'h3);
        chk("os_rearm_ctrl", 64'(ctrl[5:3]), 64'(3'b011));
        step(1);
        chk("os_rematch_cnt",  64'(count[63:32]), 64'(2));
        chk("os_rematch_ctrl", 64'(ctrl[5:3]),    64'(3'b010));
        chk("os_rematch_st",   64'(status[1]),    64'(1));

        // Wrap through all-ones, then load beating a match.
        do_reset();
        wr(0, 1, 0, 0, 2'd0, 32'd5);
        wr(1, 0, 0, 0, 2'd0, 32'hFFFF_FFFE);
        wr(0, 0, 1, 0, 2'd0, 32'h1);
        chk("wr_loaded", 64'(count[31:0]), 64'(32'hFFFF_FFFE));
        step(1);
        chk("wr_ones", 64'(count[31:0]), 64'(32'hFFFF_FFFF));
        step(1);
        chk("wr_zero",    64'(count[31:0]), 64'(0));
        chk("wr_no_flag", 64'(status[0]),   64'(0));
        step(5);
        chk("wr_at5",    64'(count[31:0]), 64'(5));
        chk("wr_st_pre", 64'(status[0]),   64'(0));
        step(1);
        chk("wr_restart", 64'(count[31:0]), 64'(0));
        chk("wr_st",      64'(status[0]),   64'(1));
        wr(0, 0, 0, 1, 2'd0, 32'h1);
        step(4);
        chk("ld_at5", 64'(count[31:0]), 64'(5));
        wr(1, 0, 0, 0, 2'd0, 32'h100);
        chk("ld_win",     64'(count[31:0]), 64'(32'h100));
        chk("ld_no_flag", 64'(status[0]),   64'(0));
        step(1);
        chk("ld_inc", 64'(count[31:0]), 64'(32'h101));

        // Set beats clear on the same edge.
        do_reset();
        wr(0, 1, 0, 0, 2'd0, 32'd1);
        wr(0, 0, 1, 0, 2'd0, 32'h1);
        step(1);
        wr(0, 0, 0, 1, 2'd0, 32'h1);
        chk("col_st",  64'(status[0]),   64'(1));
        chk("col_cnt", 64'(count[31:0]), 64'(0));
        wr(0, 0, 0, 1, 2'd0, 32'h1);
        chk("col_clr", 64'(status[0]), 64'(0));

        // Out-of-range select, then three channels on their own schedules.
        do_reset();
        wr(1, 1, 1, 0, 2'd3, 32'h7);
        chk("sel3_count",   64'(count),   64'(0));
        chk("sel3_compare", 64'(compare), 64'({NCH*W{1'b1}}));
        chk("sel3_ctrl",    64'(ctrl),    64'(0));
        wr(0, 1, 0, 0, 2'd0, 32'd1);
        wr(0, 1, 0, 0, 2'd1, 32'd4);
        wr(0, 1, 0, 0, 2'd2, 32'd7);
        wr(0, 0, 1, 0, 2'd0, 32'h1);
        wr(0, 0, 1, 0, 2'd1, 32'h1);
        wr(0, 0, 1, 0, 2'd2, 32'h1);
        chk("ind_c2",  64'(status), 64'(3'b001));
        step(3);
        chk("ind_c5",  64'(status), 64'(3'b001));
        step(1);
        chk("ind_c6",  64'(status), 64'(3'b011));
        step(3);
        chk("ind_c9",  64'(status), 64'(3'b011));
        step(1);
        chk("ind_c10", 64'(status),       64'(3'b111));
        chk("ind_cnt0", 64'(count[31:0]),  64'(0));
        chk("ind_cnt1", 64'(count[63:32]), 64'(4));
        chk("ind_cnt2", 64'(count[95:64]), 64'(0));

        // Asynchronous reset between edges while irq is high.
        do_reset();
        wr(0, 1, 0, 0, 2'd0, 32'd1);
        wr(0, 0, 1, 0, 2'd0, 32'h5);
        step(3);
        chk("ar_irq_pre", 64'(irq), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("ar_count",   64'(count),   64'(0));
        chk("ar_compare", 64'(compare), 64'({NCH*W{1'b1}}));
        chk("ar_ctrl",    64'(ctrl),    64'(0));
        chk("ar_status",  64'(status),  64'(0));
        chk("ar_irq",     64'(irq),     64'(0));
        step(1);
        reset = 1'b1;
        step(3);
        chk("ar_idle_cnt", 64'(count), 64'(0));
        chk("ar_idle_irq", 64'(irq),   64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_timer_core.md
Name: multi_timer_core

Overview:
- Parametrised multi-channel counter/timer core, successor to the two-counter core.
- Holds NUM_CH independent WIDTH-bit counters, each with:
  - a compare register
  - a per-channel control field: enable, free-run/one-shot mode, interrupt enable
  - a sticky match flag
- Sits behind the peripheral bus-interface block, which decodes register accesses into the write strobes below.
- Drives one combined, registered interrupt line.

Parameters:
- NUM_CH, default 2: number of channels, 1..32. Must satisfy NUM_CH <= WIDTH.
- WIDTH, default 32: counter and compare width in bits, 8..32.
- CH_BITS, derived as max(1, $clog2(NUM_CH)): width of the channel select. Local parameter, not overridable.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset: asserted at 0, released synchronously by the integrating block.
- sel  input  CH_BITS  channel targeted by countWe, compareWe, ctrlWe. Values >= NUM_CH: writes ignored.
- wrData  input  WIDTH  write data for all strobes.
- countWe  input  1  load count[sel] <= wrData.
- compareWe  input  1  load compare[sel] <= wrData.
- ctrlWe  input  1  load ctrl[sel] <= wrData[2:0]. Bit0 = en, bit1 = oneShot, bit2 = irqEn.
- statusClr  input  1  write-one-to-clear: clears status[i] wherever wrData[i]=1, for i < NUM_CH. Ignores sel.
- count  output  NUM_CH*WIDTH  current counters; channel i at [i*WIDTH +: WIDTH].
- compare  output  NUM_CH*WIDTH  compare registers, same packing.
- ctrl  output  NUM_CH*3  control fields; channel i at [i*3 +: 3].
- status  output  NUM_CH  sticky match flags.
- irq  output  1  registered interrupt request.

Behaviour:
Reset (reset=0, asynchronous), all values hold until first clk edge after release:
- count = 0
- compare = all-ones
- ctrl = 0
- status = 0
- irq = 0

Per channel i, each rising edge, in priority order:
1. countWe && sel==i: count[i] <= wrData. No match evaluation and no increment this cycle.
2. Else if en[i]==1 && count[i]==compare[i]:
   - status[i] set.
   - Free-run (oneShot=0): count[i] <= 0. Period = compare+1 cycles.
   - One-shot (oneShot=1): count[i] holds; en[i] cleared by hardware.
3. Else if en[i]==1: count[i] <= count[i]+1, modulo 2^WIDTH. Wraps all-ones -> 0 silently with no flag; covers count loaded above compare.
4. Else: count[i] holds.

Register update rules:
- compareWe and ctrlWe update at the edge; new values take effect for evaluation the following cycle. Each strobe targets only sel.
- ctrlWe collides with a one-shot hardware clear of the same channel: the written value wins. Writing en=1 re-arms the one-shot from the current count.
- Status set and statusClr on the same bit in the same cycle: set wins (flag stays 1).
- Multiple strobes in one cycle are legal; each acts on its own register.

Interrupt:
- irq <= OR over i of (status[i] & irqEn[i]).
- A flag set at edge k raises irq at edge k+1. irq falls one edge after the last contributing flag or irqEn clears.
- Setting irqEn while a flag is already pending raises irq one edge later.

General:
- No combinational path from inputs to outputs. All outputs are registers.
- Expected RTL size 150-250 lines: generate loop per channel plus irq reduction.

Test Plan:
1. Free-run, defaults. compare[0]=3; ctrl[0]=3'b101 (en, free-run, irqEn) -> count[0] reads 0,1,2,3,0,1,... One edge after count=3, status[0]=1; irq=1 the following edge. statusClr with wrData=1 -> status[0]=0, irq=0 one edge later.
2. One-shot. compare[1]=2; ctrl[1]=3'b011 -> count[1] 0,1,2 then holds at 2; en[1] reads 0; status[1]=1; irq stays 0 (irqEn=0). Rewrite ctrl[1]=3'b011 -> count holds 2, immediate rematch, status stays 1.
3. Wrap and load priority. WIDTH=32, compare[0]=5, count[0] loaded 0xFFFFFFFE, en=1 -> 0xFFFFFFFF, 0x0, ..., 5, then 0, with exactly one status set. countWe issued on the same edge as a match -> loaded value appears, no flag set.
4. Set/clear collision. statusClr mask 1 on the same edge as channel-0 match -> status[0]=1 afterwards. Clear one edge later -> 0.
5. Channel independence and select range. NUM_CH=3: run all channels with compares 1, 4, 7 -> flags set on their own schedules. Writes with sel=3 alter nothing.
6. Reset mid-operation. Drive reset=0 asynchronously between edges while counting with irq=1 -> all outputs return to reset values immediately; after release, counting stays off until ctrl is rewritten.
